// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } hazardState_t;

   // Register x0 is hard-wired zero, so a load targeting it never creates a hazard.
   localparam int ZERO_REG = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, cleared by rst_i.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {W{1'b1}})) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Five-stage pipeline sequencer: load-use bubbles, memory-wait freezes, branch flushes,
// plus saturating stall/flush counters and a sticky memory-timeout error.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              branch_taken_i,
   input  logic              mem_req_i,
   input  logic              mem_ready_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              noop_o,
   output logic              ifid_flush_o,
   output logic              pipe_stall_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   hazardState_t   stateReg, stateNext;
   logic [WCW-1:0] waitCntReg, waitCntNext;
   logic           errReg, errNext;

   logic memStall, loadUse;
   logic runPc, runIfid, runNoop, runFlush, runStall;
   logic stallInc;

   always_comb begin
      memStall = mem_req_i & ~mem_ready_i;
      loadUse  = ex_memread_i && (ex_rd_i != REG_AW'(ZERO_REG)) &&
                 ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

      // Decode used by RUN and by the MEM_WAIT cycle in which memory completes.
      runPc    = 1'b1;
      runIfid  = 1'b1;
      runNoop  = 1'b0;
      runFlush = 1'b0;
      runStall = 1'b0;
      if (memStall) begin
         runPc    = 1'b0;
         runIfid  = 1'b0;
         runStall = 1'b1;
      end else if (loadUse) begin
         // Branch is suppressed: it re-resolves once the bubble has passed.
         runPc    = 1'b0;
         runIfid  = 1'b0;
         runNoop  = 1'b1;
      end else if (branch_taken_i) begin
         runFlush = 1'b1;
      end

      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      noop_o       = 1'b0;
      ifid_flush_o = 1'b0;
      pipe_stall_o = 1'b0;
      stateNext    = stateReg;
      waitCntNext  = waitCntReg;
      errNext      = errReg;

      case (stateReg)
         IDLE: begin
            noop_o = 1'b1;
            if (start_i) stateNext = RUN;
         end
         RUN: begin
            pc_write_o   = runPc;
            ifid_write_o = runIfid;
            noop_o       = runNoop;
            ifid_flush_o = runFlush;
            pipe_stall_o = runStall;
            if (memStall) begin
               stateNext   = MEM_WAIT;
               waitCntNext = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready_i) begin
               pc_write_o   = runPc;
               ifid_write_o = runIfid;
               noop_o       = runNoop;
               ifid_flush_o = runFlush;
               pipe_stall_o = runStall;
               stateNext    = RUN;
               waitCntNext  = '0;
            end else begin
               pipe_stall_o = 1'b1;
               if (waitCntReg == WCW'(MEM_TIMEOUT - 1)) begin
                  stateNext = ERROR;
                  errNext   = 1'b1;
               end else begin
                  waitCntNext = waitCntReg + WCW'(1);
               end
            end
         end
         default: begin
            pipe_stall_o = 1'b1;
            noop_o       = 1'b1;
         end
      endcase

      stallInc = ((stateReg == RUN) || (stateReg == MEM_WAIT)) && !pc_write_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stateReg   <= IDLE;
         waitCntReg <= '0;
         errReg     <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         waitCntReg <= waitCntNext;
         errReg     <= errNext;
      end
   end

   assign err_o = errReg;

   sat_counter #(.W(CNT_W)) stallCounter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stallInc),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) flushCounter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ifid_flush_o),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] idRs1 = '0, idRs2 = '0, exRd = '0;
   logic       exMemread = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memReady = 1'b0;
   logic       pcWrite, ifidWrite, noop, ifidFlush, pipeStall, err;
   logic [3:0] stallCnt, flushCnt;
   logic [4:0] outs;

   int passCnt = 0;
   int totalCnt = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_AW(5), .CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .id_rs1_i       (idRs1),
      .id_rs2_i       (idRs2),
      .ex_memread_i   (exMemread),
      .ex_rd_i        (exRd),
      .branch_taken_i (branchTaken),
      .mem_req_i      (memReq),
      .mem_ready_i    (memReady),
      .pc_write_o     (pcWrite),
      .ifid_write_o   (ifidWrite),
      .noop_o         (noop),
      .ifid_flush_o   (ifidFlush),
      .pipe_stall_o   (pipeStall),
      .err_o          (err),
      .stall_cnt_o    (stallCnt),
      .flush_cnt_o    (flushCnt)
   );

   // {pc_write, ifid_write, noop, flush, pipe_stall}
   assign outs = {pcWrite, ifidWrite, noop, ifidFlush, pipeStall};

   localparam logic [4:0] O_IDLE  = 5'b00100;
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_BUBL  = 5'b00100;
   localparam logic [4:0] O_FLUSH = 5'b11010;
   localparam logic [4:0] O_FRZ   = 5'b00001;
   localparam logic [4:0] O_ERR   = 5'b00101;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalCnt++;
      if (got === exp) begin
         passCnt++;
         $display("ok   %-14s got=%0h", tag, got);
      end else begin
         $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clearHazards();
      exMemread = 1'b0; exRd = '0; idRs1 = '0; idRs2 = '0;
      branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0; settle();
      checkEq("reset_outs", 32'(outs), 32'(O_IDLE));
      checkEq("reset_err", 32'(err), 32'd0);
      checkEq("reset_stallc", 32'(stallCnt), 32'd0);
      checkEq("reset_flushc", 32'(flushCnt), 32'd0);

      start = 1'b1; settle();
      checkEq("idle_start", 32'(outs), 32'(O_IDLE));
      tick(); start = 1'b0; settle();
      checkEq("run_first", 32'(outs), 32'(O_RUN));

      // Load-use on rs2
      exMemread = 1'b1; exRd = 5'd5; idRs1 = 5'd3; idRs2 = 5'd5; settle();
      checkEq("loaduse", 32'(outs), 32'(O_BUBL));
      tick(); clearHazards(); settle();
      checkEq("loaduse_after", 32'(outs), 32'(O_RUN));
      checkEq("loaduse_stallc", 32'(stallCnt), 32'd1);

      // rd = x0 is never a hazard
      exMemread = 1'b1; exRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0; settle();
      checkEq("rd_zero", 32'(outs), 32'(O_RUN));
      tick(); clearHazards(); settle();
      checkEq("rd_zero_stallc", 32'(stallCnt), 32'd1);

      // Load-use beats branch, then branch flushes
      exMemread = 1'b1; exRd = 5'd7; idRs1 = 5'd7; branchTaken = 1'b1; settle();
      checkEq("lu_vs_branch", 32'(outs), 32'(O_BUBL));
      tick(); exMemread = 1'b0; settle();
      checkEq("branch_flush", 32'(outs), 32'(O_FLUSH));
      tick(); clearHazards(); settle();
      checkEq("after_flush", 32'(outs), 32'(O_RUN));
      checkEq("flushc_one", 32'(flushCnt), 32'd1);
      checkEq("stallc_two", 32'(stallCnt), 32'd2);

      // Zero-latency memory access costs nothing
      memReq = 1'b1; memReady = 1'b1; settle();
      checkEq("mem_zero_lat", 32'(outs), 32'(O_RUN));
      tick(); clearHazards(); settle();
      checkEq("mem_zl_stallc", 32'(stallCnt), 32'd2);

      // Three-cycle memory wait; hazard/branch ignored while frozen
      memReq = 1'b1; settle();
      checkEq("memw_c1", 32'(outs), 32'(O_FRZ));
      tick(); settle();
      checkEq("memw_c2", 32'(outs), 32'(O_FRZ));
      tick(); exMemread = 1'b1; exRd = 5'd4; idRs1 = 5'd4; branchTaken = 1'b1; settle();
      checkEq("memw_c3_ign", 32'(outs), 32'(O_FRZ));
      tick(); clearHazards(); memReady = 1'b1; settle();
      checkEq("memw_ready", 32'(outs), 32'(O_RUN));
      tick(); clearHazards(); settle();
      checkEq("memw_back_run", 32'(outs), 32'(O_RUN));
      checkEq("memw_stallc", 32'(stallCnt), 32'd5);
      checkEq("memw_flushc", 32'(flushCnt), 32'd1);

      // Timeout: four stalled cycles, then ERROR
      memReq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checkEq($sformatf("tmo_frz%0d", i), 32'(outs), 32'(O_FRZ));
         checkEq($sformatf("tmo_err%0d", i), 32'(err), 32'd0);
         tick();
      end
      settle();
      checkEq("err_outs", 32'(outs), 32'(O_ERR));
      checkEq("err_flag", 32'(err), 32'd1);
      checkEq("err_stallc", 32'(stallCnt), 32'd9);
      memReady = 1'b1; start = 1'b1;
      tick(); tick(); start = 1'b0; settle();
      checkEq("err_sticky", 32'(err), 32'd1);
      checkEq("err_stay_outs", 32'(outs), 32'(O_ERR));
      checkEq("err_no_count", 32'(stallCnt), 32'd9);

      rst = 1'b1; clearHazards();
      tick(); rst = 1'b0; settle();
      checkEq("err_rst_outs", 32'(outs), 32'(O_IDLE));
      checkEq("err_rst_flag", 32'(err), 32'd0);
      checkEq("err_rst_cnt", 32'(stallCnt), 32'd0);

      // Saturation with a held load-use hazard
      start = 1'b1; tick(); start = 1'b0;
      exMemread = 1'b1; exRd = 5'd9; idRs2 = 5'd9;
      for (int i = 0; i < 14; i++) tick();
      settle();
      checkEq("sat_14", 32'(stallCnt), 32'd14);
      tick(); settle();
      checkEq("sat_15", 32'(stallCnt), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      settle();
      checkEq("sat_hold", 32'(stallCnt), 32'd15);
      checkEq("sat_outs", 32'(outs), 32'(O_BUBL));

      // Reset mid memory wait forgets the request
      clearHazards(); tick();
      memReq = 1'b1; tick(); settle();
      checkEq("mw_pre_rst", 32'(outs), 32'(O_FRZ));
      rst = 1'b1; tick(); rst = 1'b0; clearHazards(); settle();
      checkEq("mw_rst_idle", 32'(outs), 32'(O_IDLE));
      start = 1'b1; tick(); start = 1'b0; settle();
      checkEq("mw_rst_run", 32'(outs), 32'(O_RUN));

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

endmodule
